// File: rtl/frame_reader_if.sv
// frame_reader bus bundle: image RAM read port and pixel stream.
// master = frame_reader side, slave = RAM model / stream consumer.
interface frame_reader_if;
    logic [7:0] xAddressOut;
    logic [7:0] yAddressOut;
    logic       memWrite;
    logic       memDataIn;
    logic       pixelOut;
    logic [7:0] pixelX;
    logic [7:0] pixelY;
    logic       startOfFrame;
    logic       endOfLine;
    logic       endOfFrame;
    logic       pixelValid;
    logic       pixelReady;

    modport master (
        output xAddressOut, yAddressOut, memWrite,
        output pixelOut, pixelX, pixelY,
        output startOfFrame, endOfLine, endOfFrame,
        output pixelValid,
        input  memDataIn, pixelReady
    );

    modport slave (
        input  xAddressOut, yAddressOut, memWrite,
        input  pixelOut, pixelX, pixelY,
        input  startOfFrame, endOfLine, endOfFrame,
        input  pixelValid,
        output memDataIn, pixelReady
    );
endinterface

// File: rtl/frame_reader.sv
// frame_reader: raster-scans one frame out of a fixed-latency image RAM
// and streams tagged pixels through a small credit-controlled FIFO.
module frame_reader #(
    parameter int IMWIDTH      = 240,
    parameter int IMHEIGHT     = 180,
    parameter int READ_LATENCY = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    frame_reader_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
    localparam logic [7:0] XMAX = 8'(IMWIDTH - 1);
    localparam logic [7:0] YMAX = 8'(IMHEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic       v;
        logic [7:0] x;
        logic [7:0] y;
    } tag_t;

    typedef struct packed {
        logic       pix;
        logic [7:0] x;
        logic [7:0] y;
    } entry_t;

    state_t        state;
    logic [7:0]    x;
    logic [7:0]    y;
    logic [7:0]    xAddr;
    logic [7:0]    yAddr;
    logic          issueValid;
    tag_t          tagPipe [READ_LATENCY];
    entry_t        fifoMem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] fifoCount;
    logic [CW-1:0] inflight;

    logic   canIssue;
    logic   issueNow;
    logic   push;
    logic   pop;
    logic   headValid;
    logic   lastPixel;
    logic   drained;
    entry_t head;

    // Inflight covers the address register plus every tag stage, so
    // inflight + fifoCount is every slot already promised to a read.
    assign canIssue  = (inflight + fifoCount) < CW'(FIFO_DEPTH);
    assign issueNow  = (state == ISSUE) && canIssue;
    assign push      = tagPipe[READ_LATENCY-1].v;
    assign headValid = (fifoCount != '0);
    assign pop       = headValid && bus.pixelReady;
    assign head      = fifoMem[rdPtr];
    assign lastPixel = (x == XMAX) && (y == YMAX);
    assign drained   = (inflight == '0)
                    && ((fifoCount == '0)
                     || ((fifoCount == CW'(1)) && pop));

    // Frame sequencing: scan position, RAM address register, busy/done.
    // The address register keeps the last issued read while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            xAddr      <= '0;
            yAddr      <= '0;
            issueValid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            issueValid <= issueNow;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                ISSUE: begin
                    if (issueNow) begin
                        xAddr <= x;
                        yAddr <= y;
                        if (lastPixel) begin
                            state <= DRAIN;
                        end else if (x == XMAX) begin
                            x <= '0;
                            y <= y + 8'd1;
                        end else begin
                            x <= x + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline: follows each read until its data appears on memDataIn.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                tagPipe[k] <= '0;
            end
        end else begin
            tagPipe[0] <= '{v: issueValid, x: xAddr, y: yAddr};
            for (int k = 1; k < READ_LATENCY; k++) begin
                tagPipe[k] <= tagPipe[k-1];
            end
        end
    end

    // FIFO storage: returning pixel plus its tag.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= '{
                pix: bus.memDataIn,
                x:   tagPipe[READ_LATENCY-1].x,
                y:   tagPipe[READ_LATENCY-1].y
            };
        end
    end

    // FIFO pointers and the two credit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            inflight  <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            fifoCount <= fifoCount + CW'(push) - CW'(pop);
            inflight  <= inflight + CW'(issueNow) - CW'(push);
        end
    end

    assign bus.memWrite     = 1'b0;
    assign bus.xAddressOut  = xAddr;
    assign bus.yAddressOut  = yAddr;
    assign bus.pixelValid   = headValid;
    assign bus.pixelOut     = headValid & head.pix;
    assign bus.pixelX       = headValid ? head.x : 8'd0;
    assign bus.pixelY       = headValid ? head.y : 8'd0;
    assign bus.startOfFrame = headValid
                           && (head.x == 8'd0) && (head.y == 8'd0);
    assign bus.endOfLine    = headValid && (head.x == XMAX);
    assign bus.endOfFrame   = headValid
                           && (head.x == XMAX) && (head.y == YMAX);
endmodule
